// File: rtl/alu_issue_queue.sv
// Operand/issue stage in front of the registered ALU: buffers operations in a
// small FIFO and issues them, stalling one cycle when operand A needs the last result.
module alu_issue_queue #(
   parameter int NUMBITS = 16,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUMBITS-1:0]       in_a,
   input  logic [NUMBITS-1:0]       in_b,
   input  logic [2:0]               in_opcode,
   input  logic                     in_fwd_a,
   output logic [NUMBITS-1:0]       alu_a,
   output logic [NUMBITS-1:0]       alu_b,
   output logic [2:0]               alu_opcode,
   input  logic [NUMBITS-1:0]       alu_result,
   output logic                     issue_valid,
   output logic                     res_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [NUMBITS-1:0] a_mem   [DEPTH];
   logic [NUMBITS-1:0] b_mem   [DEPTH];
   logic [2:0]         op_mem  [DEPTH];
   logic               fwd_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          have_result;
   logic          push;
   logic          pop;
   logic          hazard;

   // Input handshake: an operation transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready depends only on occupancy, never on a same-cycle pop.
   assign in_ready = (count < FULL);
   assign push     = in_valid && in_ready;

   // The previous op's result lands on alu_result only one edge after it issued.
   assign hazard = fwd_mem[rd_ptr] && issue_valid;
   assign pop    = (count != '0) && !hazard;

   always_ff @(posedge clk) begin
      if (push) begin
         a_mem[wr_ptr]   <= in_a;
         b_mem[wr_ptr]   <= in_b;
         op_mem[wr_ptr]  <= in_opcode;
         fwd_mem[wr_ptr] <= in_fwd_a;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_opcode  <= '0;
         issue_valid <= 1'b0;
         res_valid   <= 1'b0;
         have_result <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr      <= rd_ptr + PW'(1);
            alu_b       <= b_mem[rd_ptr];
            alu_opcode  <= op_mem[rd_ptr];
            have_result <= 1'b1;
            if (!fwd_mem[rd_ptr])  alu_a <= a_mem[rd_ptr];
            else if (have_result)  alu_a <= alu_result;
            else                   alu_a <= '0;
         end
         issue_valid <= pop;
         res_valid   <= issue_valid;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
